// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared types and constants for the SAP controller sequencer
// Purpose: opcode constants, T-state enum, control-word layout and helpers.
// Ports: none (package).
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam int CW_W = 13;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      T4   = 3'd4,
      T5   = 3'd5,
      T6   = 3'd6,
      HALT = 3'd7
   } t_state_e;

   // Control word, MSB first; 13 bits wide to match CW_W.
   typedef struct packed {
      logic halt;
      logic pc_inc;
      logic pc_out;
      logic mar_load_n;
      logic ram_out;
      logic ir_load_n;
      logic ir_out;
      logic a_load_n;
      logic a_out;
      logic b_load_n;
      logic alu_sub;
      logic alu_out;
      logic out_load_n;
   } cw_t;

   // Strobes high (inactive), enables low.
   localparam cw_t CW_IDLE = '{
      halt: 1'b0, pc_inc: 1'b0, pc_out: 1'b0, mar_load_n: 1'b1,
      ram_out: 1'b0, ir_load_n: 1'b1, ir_out: 1'b0, a_load_n: 1'b1,
      a_out: 1'b0, b_load_n: 1'b1, alu_sub: 1'b0, alu_out: 1'b0,
      out_load_n: 1'b1
   };

   // Opcodes with no execute phase.
   function automatic logic is_nop(input logic [3:0] op);
      return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
               op == OP_OUT || op == OP_HLT);
   endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// rtl/controller_sequencer_if.sv - run/opcode inputs and control-word outputs
// Purpose: bundles the sequencer's handshake and control lines.
// Ports (signals): run, opcode[3:0] into the sequencer; pc_inc, pc_out,
//   mar_load_n, ram_out, ir_load_n, ir_out, a_load_n, a_out, b_load_n,
//   alu_sub, alu_out, out_load_n, halt out of the sequencer.
// master = sequencer side, slave = datapath/driver side.
interface controller_sequencer_if;
   logic       run;
   logic [3:0] opcode;
   logic       pc_inc;
   logic       pc_out;
   logic       mar_load_n;
   logic       ram_out;
   logic       ir_load_n;
   logic       ir_out;
   logic       a_load_n;
   logic       a_out;
   logic       b_load_n;
   logic       alu_sub;
   logic       alu_out;
   logic       out_load_n;
   logic       halt;

   modport master (
      input  run, opcode,
      output pc_inc, pc_out, mar_load_n, ram_out, ir_load_n, ir_out,
             a_load_n, a_out, b_load_n, alu_sub, alu_out, out_load_n, halt
   );

   modport slave (
      output run, opcode,
      input  pc_inc, pc_out, mar_load_n, ram_out, ir_load_n, ir_out,
             a_load_n, a_out, b_load_n, alu_sub, alu_out, out_load_n, halt
   );
endinterface

// File: rtl/controller_sequencer_t_state_counter.sv
// rtl/controller_sequencer_t_state_counter.sv - T-state register and next-state logic
// Purpose: steps IDLE -> T1..T6 -> T1, enters HALT on HLT at T4, freezes when run=0.
// Config: SEQ_EARLY_END_EN shortens instructions to their last active T-state.
// Ports: clk, rst_n (async active-low), run, opcode[3:0] in; state_o out.
module t_state_counter
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] opcode,
   output t_state_e   state_o
);

   t_state_e state_q;
   t_state_e state_d;

   always_comb begin
      state_d = state_q;
      if (run) begin
         case (state_q)
            IDLE: state_d = T1;
            T1:   state_d = T2;
            T2:   state_d = T3;
`ifdef SEQ_EARLY_END_EN
            T3:   state_d = is_nop(opcode) ? T1 : T4;
            T4: begin
               if (opcode == OP_HLT)      state_d = HALT;
               else if (opcode == OP_OUT) state_d = T1;
               else                       state_d = T5;
            end
            T5:   state_d = (opcode == OP_LDA) ? T1 : T6;
`else
            T3:   state_d = T4;
            T4:   state_d = (opcode == OP_HLT) ? HALT : T5;
            T5:   state_d = T6;
`endif
            T6:   state_d = T1;
            HALT: state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-style microcode sequencer top
// Purpose: decodes the T-state and opcode into the datapath control word.
// Config: SEQ_EARLY_END_EN (see t_state_counter) ends instructions early.
// Ports: clk, rst_n (async active-low); bus (controller_sequencer_if.master)
//   carrying run/opcode in and the 13 control outputs.
module controller_sequencer
   import sap_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   controller_sequencer_if.master       bus
);

   t_state_e        state;
   cw_t             cw;
   cw_t             cw_o;
   logic [CW_W-1:0] cw_word;

   t_state_counter u_t_state_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (bus.run),
      .opcode  (bus.opcode),
      .state_o (state)
   );

   // Opcode is only consulted in T4-T6, so IR reloads during fetch are invisible.
   always_comb begin
      cw = CW_IDLE;
      case (state)
         T1: begin
            cw.pc_out     = 1'b1;
            cw.mar_load_n = 1'b0;
         end
         T2: cw.pc_inc = 1'b1;
         T3: begin
            cw.ram_out   = 1'b1;
            cw.ir_load_n = 1'b0;
         end
         T4: begin
            case (bus.opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  cw.ir_out     = 1'b1;
                  cw.mar_load_n = 1'b0;
               end
               OP_OUT: begin
                  cw.a_out      = 1'b1;
                  cw.out_load_n = 1'b0;
               end
               default: ;
            endcase
         end
         T5: begin
            case (bus.opcode)
               OP_LDA: begin
                  cw.ram_out  = 1'b1;
                  cw.a_load_n = 1'b0;
               end
               OP_ADD, OP_SUB: begin
                  cw.ram_out  = 1'b1;
                  cw.b_load_n = 1'b0;
                  cw.alu_sub  = (bus.opcode == OP_SUB);
               end
               default: ;
            endcase
         end
         T6: begin
            if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
               cw.alu_out  = 1'b1;
               cw.a_load_n = 1'b0;
               cw.alu_sub  = (bus.opcode == OP_SUB);
            end
         end
         HALT: cw.halt = 1'b1;
         default: ;
      endcase
   end

   // run=0 blanks everything, halt included, while the state stays frozen.
   assign cw_word = bus.run ? cw : CW_IDLE;
   assign cw_o    = cw_t'(cw_word);

   assign bus.halt       = cw_o.halt;
   assign bus.pc_inc     = cw_o.pc_inc;
   assign bus.pc_out     = cw_o.pc_out;
   assign bus.mar_load_n = cw_o.mar_load_n;
   assign bus.ram_out    = cw_o.ram_out;
   assign bus.ir_load_n  = cw_o.ir_load_n;
   assign bus.ir_out     = cw_o.ir_out;
   assign bus.a_load_n   = cw_o.a_load_n;
   assign bus.a_out      = cw_o.a_out;
   assign bus.b_load_n   = cw_o.b_load_n;
   assign bus.alu_sub    = cw_o.alu_sub;
   assign bus.alu_out    = cw_o.alu_out;
   assign bus.out_load_n = cw_o.out_load_n;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - directed self-checking bench for controller_sequencer
module tb_controller_sequencer;

   // Bit order: halt,pc_inc,pc_out,mar_n,ram_out,ir_n,ir_out,a_n,a_out,b_n,alu_sub,alu_out,out_n
   localparam logic [12:0] W_IDLE = 13'b0_0_0_1_0_1_0_1_0_1_0_0_1;
   localparam logic [12:0] W_T1   = 13'b0_0_1_0_0_1_0_1_0_1_0_0_1;
   localparam logic [12:0] W_T2   = 13'b0_1_0_1_0_1_0_1_0_1_0_0_1;
   localparam logic [12:0] W_T3   = 13'b0_0_0_1_1_0_0_1_0_1_0_0_1;
   localparam logic [12:0] W_ADDR = 13'b0_0_0_0_0_1_1_1_0_1_0_0_1;
   localparam logic [12:0] W_LDA5 = 13'b0_0_0_1_1_1_0_0_0_1_0_0_1;
   localparam logic [12:0] W_ADD5 = 13'b0_0_0_1_1_1_0_1_0_0_0_0_1;
   localparam logic [12:0] W_SUB5 = 13'b0_0_0_1_1_1_0_1_0_0_1_0_1;
   localparam logic [12:0] W_ADD6 = 13'b0_0_0_1_0_1_0_0_0_1_0_1_1;
   localparam logic [12:0] W_SUB6 = 13'b0_0_0_1_0_1_0_0_0_1_1_1_1;
   localparam logic [12:0] W_OUT4 = 13'b0_0_0_1_0_1_0_1_1_1_0_0_0;
   localparam logic [12:0] W_HALT = 13'b1_0_0_1_0_1_0_1_0_1_0_0_1;

   logic clk;
   logic rst_n;
   logic mon_en;
   int   n_checks;
   int   n_errors;

   controller_sequencer_if bus ();

   controller_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] obs();
      return {bus.halt, bus.pc_inc, bus.pc_out, bus.mar_load_n, bus.ram_out,
              bus.ir_load_n, bus.ir_out, bus.a_load_n, bus.a_out, bus.b_load_n,
              bus.alu_sub, bus.alu_out, bus.out_load_n};
   endfunction

   // Check the current cycle's control word, then move to the next cycle.
   task automatic cyc(input string tag, input logic [12:0] exp);
      #1;
      check(tag, obs(), exp);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("bus_onehot0",
               {12'd0, $onehot0({bus.pc_out, bus.ram_out, bus.ir_out, bus.a_out, bus.alu_out})},
               13'd1);
      end
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      mon_en     = 1'b0;
      rst_n      = 1'b0;
      bus.run    = 1'b0;
      bus.opcode = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      bus.run = 1'b1;
      #1;
      check("reset_idle", obs(), W_IDLE);
      mon_en = 1'b1;
      rst_n  = 1'b1;

      // LDA
      cyc("lda_c1_idle", W_IDLE);
      cyc("lda_t1", W_T1);
      cyc("lda_t2", W_T2);
      cyc("lda_t3", W_T3);
      cyc("lda_t4", W_ADDR);
      cyc("lda_t5", W_LDA5);
`ifndef SEQ_EARLY_END_EN
      cyc("lda_t6", W_IDLE);
`endif

      // SUB
      bus.opcode = 4'h2;
      cyc("sub_t1", W_T1);
      cyc("sub_t2", W_T2);
      cyc("sub_t3", W_T3);
      cyc("sub_t4", W_ADDR);
      cyc("sub_t5", W_SUB5);
      cyc("sub_t6", W_SUB6);

      // ADD with opcode noise during fetch
      bus.opcode = 4'hF;
      cyc("sub_next_t1", W_T1);
      bus.opcode = 4'hE;
      cyc("add_t2_opnoise", W_T2);
      bus.opcode = 4'h1;
      cyc("add_t3", W_T3);
      cyc("add_t4", W_ADDR);
      cyc("add_t5", W_ADD5);
      cyc("add_t6", W_ADD6);

      // OUT
      bus.opcode = 4'hE;
      cyc("out_t1", W_T1);
      cyc("out_t2", W_T2);
      cyc("out_t3", W_T3);
      cyc("out_t4", W_OUT4);
`ifndef SEQ_EARLY_END_EN
      cyc("out_t5", W_IDLE);
      cyc("out_t6", W_IDLE);
`endif
      cyc("out_next_t1", W_T1);

      // Freeze at T2
      bus.run = 1'b0;
      repeat (3) cyc("freeze_idle", W_IDLE);
      bus.run = 1'b1;
      cyc("resume_t2", W_T2);

      // HLT
      bus.opcode = 4'hF;
      cyc("hlt_t3", W_T3);
      cyc("hlt_t4_idle", W_IDLE);
      repeat (22) cyc("halted", W_HALT);
      bus.run = 1'b0;
      cyc("halt_frozen", W_IDLE);
      bus.run = 1'b1;
      cyc("halt_resume", W_HALT);

      // Reset pulse out of HALT
      rst_n = 1'b0;
      #1;
      check("rst_in_halt", obs(), W_IDLE);
      @(posedge clk);
      #1;
      check("rst_held", obs(), W_IDLE);
      rst_n = 1'b1;
      cyc("post_rst_idle", W_IDLE);
      cyc("post_rst_t1", W_T1);

      // Reset during T5 of ADD
      bus.opcode = 4'h1;
      cyc("add2_t2", W_T2);
      cyc("add2_t3", W_T3);
      cyc("add2_t4", W_ADDR);
      #1;
      check("add2_t5", obs(), W_ADD5);
      rst_n = 1'b0;
      #1;
      check("rst_mid_b_load_n", {12'd0, bus.b_load_n}, 13'd1);
      check("rst_mid_all", obs(), W_IDLE);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("restart_idle", W_IDLE);
      cyc("restart_t1", W_T1);

      // NOP
      bus.opcode = 4'h5;
      cyc("nop_t2", W_T2);
      cyc("nop_t3", W_T3);
`ifndef SEQ_EARLY_END_EN
      cyc("nop_t4", W_IDLE);
      cyc("nop_t5", W_IDLE);
      cyc("nop_t6", W_IDLE);
`endif
      cyc("nop_next_t1", W_T1);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset. Ports are named clk and rst_n.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- run  in  1  1 = sequence; 0 = freeze state
- opcode  in  4  upper nibble of the instruction register
- pc_inc  out  1  program counter increment
- pc_out  out  1  PC drives bus
- mar_load_n  out  1  MAR loads from bus when 0
- ram_out  out  1  RAM drives bus
- ir_load_n  out  1  IR loads from bus when 0
- ir_out  out  1  IR low nibble drives bus
- a_load_n  out  1  accumulator loads from bus when 0
- a_out  out  1  accumulator drives bus
- b_load_n  out  1  B register loads when 0
- alu_sub  out  1  ALU subtract select
- alu_out  out  1  ALU drives bus
- out_load_n  out  1  output register loads when 0
- halt  out  1  sequencer halted

REQ-003 Polarity convention for all outputs:
- Load strobes (*_load_n) are active-low; idle value 1.
- Bus enables and all other outputs are active-high; idle value 0.

Function
REQ-004 States: IDLE, T1, T2, T3, T4, T5, T6, HALT. Outputs are decoded combinationally from the state register and opcode.
REQ-005 Transitions:
- IDLE->T1; Tn->Tn+1; T6->T1.
- T4 with opcode=HLT (4'hF) -> HALT.
- HALT is absorbing until reset.
REQ-006 Fetch, identical for every opcode:
- T1: pc_out=1, mar_load_n=0.
- T2: pc_inc=1.
- T3: ram_out=1, ir_load_n=0.
REQ-007 LDA (4'h0):
- T4: ir_out=1, mar_load_n=0.
- T5: ram_out=1, a_load_n=0.
- T6: idle.
REQ-008 ADD (4'h1):
- T4: ir_out=1, mar_load_n=0.
- T5: ram_out=1, b_load_n=0.
- T6: alu_out=1, a_load_n=0.
REQ-009 SUB (4'h2): as ADD, with alu_sub=1 in T5 and T6.
REQ-010 OUT (4'hE):
- T4: a_out=1, out_load_n=0.
- T5, T6: idle.
REQ-011 Any other opcode is a NOP: T4–T6 idle.
REQ-012 HLT: T4 outputs are idle. In HALT, halt=1 and all other outputs are idle.
REQ-013 At most one bus-driving enable (pc_out, ram_out, ir_out, a_out, alu_out) SHALL be 1 in any cycle.
REQ-014 run=0 freezes the state register and forces all outputs idle, halt included. When run returns to 1, decoding resumes in the frozen state with no skipped or repeated T-state.
REQ-015 opcode is sampled only during T4–T6. Changes during IDLE and T1–T3 SHALL NOT affect outputs.

Reset
REQ-016 rst_n=0 SHALL immediately (asynchronously) force state=IDLE and all outputs idle, including during HALT or mid-instruction.
REQ-017 The first rising clk edge after rst_n deasserts with run=1 SHALL enter T1.

Configuration
REQ-018 Macro SEQ_EARLY_END_EN.
- Defined: after an instruction's last active T-state the sequencer goes directly to T1. Instruction lengths: LDA 5, ADD/SUB 6, OUT 4, NOP 3 cycles. HLT behaviour is unchanged.
- Undefined: every instruction takes exactly 6 T-states.

Structure
REQ-019 Package sap_pkg SHALL hold:
- opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
- the state enum t_state_e;
- control-word width constant CW_W=13.
REQ-020 Sub-module t_state_counter SHALL hold the state register and the next-state logic. controller_sequencer SHALL hold the output decode.

Verification
REQ-021 Directed scenarios:
- Reset then run=1, opcode=4'h0 -> cycle 1 IDLE (all idle); cycle 2 pc_out=1, mar_load_n=0; T5 ram_out=1, a_load_n=0.
- opcode=4'h2 -> T5 b_load_n=0, alu_sub=1; T6 alu_out=1, a_load_n=0, alu_sub=1; next cycle T1.
- opcode=4'hF -> halt=1 from the cycle after T4, outputs idle for 20+ cycles; rst_n pulse -> IDLE, then T1.
- run=0 for 3 cycles at T2 -> outputs idle, then pc_inc=1 in the first cycle after run=1.
- rst_n asserted in T5 of ADD -> b_load_n=1 within the same cycle; restart at IDLE.
- opcode=4'hE with SEQ_EARLY_END_EN defined -> T4 a_out=1, out_load_n=0, next cycle T1. Without the macro -> T5, T6 idle, then T1.
- Assertion over all runs: REQ-013 one-hot-or-zero bus enables.
